// File: rtl/thresholding_cfg_loader.sv
// Bulk threshold loader for a thresholding kernel cfg port, with host-priority arbitration.
// Optional TLAST framing check: define THRESH_LOADER_TLAST_CHECK_EN.
module thresholding_cfg_loader #(
  parameter  int N   = 8,
  parameter  int WT  = 8,
  parameter  int C   = 1,
  parameter  int PE  = 1,
  localparam int NT  = 2**N - 1,
  localparam int CF  = C / PE,
  localparam int CFB = $clog2(CF),
  localparam int PEB = $clog2(PE),
  localparam int AW  = CFB + PEB + N,
  localparam int DW  = ((WT + 7) / 8) * 8
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          kernel_en,
  input  logic          s_thr_TVALID,
  output logic          s_thr_TREADY,
  input  logic [DW-1:0] s_thr_TDATA,
`ifdef THRESH_LOADER_TLAST_CHECK_EN
  input  logic          s_thr_TLAST,
  output logic          load_err,
`endif
  input  logic          h_en,
  input  logic          h_we,
  input  logic [AW-1:0] h_a,
  input  logic [WT-1:0] h_d,
  output logic          h_rack,
  output logic [WT-1:0] h_q,
  output logic          cfg_en,
  output logic          cfg_we,
  output logic [AW-1:0] cfg_a,
  output logic [WT-1:0] cfg_d,
  input  logic          cfg_rack,
  input  logic [WT-1:0] cfg_q
);

  // state | meaning
  // IDLE  | no threshold set loaded yet, kernel held off
  // LOAD  | accepting stream beats and writing them to cfg
  // DONE  | full set written, kernel enabled; ap_start reloads
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int CHW = (C > 1) ? $clog2(C) : 1;

  state_t         state;
  logic [N-1:0]   t;
  logic [CHW-1:0] ch;
  logic           hs;
  logic           last_beat;
  logic           t_wrap;
  logic [AW-1:0]  ch_hi;
  logic [AW-1:0]  ch_lo;
  logic [AW-1:0]  load_addr;

  assign s_thr_TREADY = (state == LOAD) && !h_en;
  assign hs           = s_thr_TREADY && s_thr_TVALID;
  assign t_wrap       = (t == N'(NT - 1));
  assign last_beat    = t_wrap && (ch == CHW'(C - 1));

  // {ch/PE, ch%PE, t}; zero-width fields fall out because their value is always 0
  always_comb begin
    ch_hi     = AW'(32'(ch) / PE);
    ch_lo     = AW'(32'(ch) % PE);
    load_addr = (ch_hi << (PEB + N)) | (ch_lo << N) | AW'(t);
  end

  // host wins the port outright; the loader just sees TREADY low that cycle
  assign cfg_en = h_en | hs;
  assign cfg_we = h_en ? h_we : hs;
  assign cfg_a  = h_en ? h_a  : load_addr;
  assign cfg_d  = h_en ? h_d  : s_thr_TDATA[WT-1:0];

  assign h_rack = cfg_rack;
  assign h_q    = cfg_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      t         <= '0;
      ch        <= '0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      kernel_en <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ap_start) begin
            state     <= LOAD;
            t         <= '0;
            ch        <= '0;
            ap_idle   <= 1'b0;
            kernel_en <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            if (last_beat) begin
              state     <= DONE;
              t         <= '0;
              ch        <= '0;
              ap_done   <= 1'b1;
              ap_idle   <= 1'b1;
              kernel_en <= 1'b1;
            end else if (t_wrap) begin
              t  <= '0;
              ch <= ch + 1'b1;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          ap_idle   <= 1'b1;
          kernel_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef THRESH_LOADER_TLAST_CHECK_EN
  // framing errors are reported but never shorten or extend the count-based load
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      load_err <= 1'b0;
    end else if ((state == IDLE || state == DONE) && ap_start) begin
      load_err <= 1'b0;
    end else if (hs && (s_thr_TLAST != last_beat)) begin
      load_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Directed bench for thresholding_cfg_loader at N=2, WT=8, C=4, PE=2 (NT=3, AW=4).
module tb_thresholding_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ap_start, ap_done, ap_idle, kernel_en;
  logic       tvalid, tready;
  logic [7:0] tdata;
  logic       h_en, h_we, h_rack;
  logic [3:0] h_a;
  logic [7:0] h_d, h_q;
  logic       cfg_en, cfg_we, cfg_rack;
  logic [3:0] cfg_a;
  logic [7:0] cfg_d, cfg_q;
`ifdef THRESH_LOADER_TLAST_CHECK_EN
  logic       tlast;
  logic       load_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [7:0] mem [16];
  int exp_addr [12] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14};

  thresholding_cfg_loader #(.N(2), .WT(8), .C(4), .PE(2)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .kernel_en(kernel_en),
    .s_thr_TVALID(tvalid), .s_thr_TREADY(tready), .s_thr_TDATA(tdata),
`ifdef THRESH_LOADER_TLAST_CHECK_EN
    .s_thr_TLAST(tlast), .load_err(load_err),
`endif
    .h_en(h_en), .h_we(h_we), .h_a(h_a), .h_d(h_d), .h_rack(h_rack), .h_q(h_q),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
    .cfg_rack(cfg_rack), .cfg_q(cfg_q)
  );

  always #5 clk = ~clk;

  // kernel cfg memory model
  always @(posedge clk) if (cfg_en && cfg_we) mem[cfg_a] <= cfg_d;
  always @(negedge clk) if (ap_done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    @(negedge clk);
    check_eq("idle_in_load", ap_idle, 0);
    check_eq("ken_in_load", kernel_en, 0);
    tick();
  endtask

  task automatic check_mem(input logic [7:0] base);
    for (int i = 0; i < 12; i++) check_eq("mem", mem[exp_addr[i]], 32'(8'(base + i)));
  endtask

  // stream 12 beats; optional idle gap before each beat, host write on host_beat,
  // TLAST on last_beat; returns early (TVALID still high) after stop_after
  task automatic stream(input logic [7:0] base, input int gap, input int host_beat,
                        input int last_beat, input int stop_after);
    for (int b = 0; b < 12; b++) begin
      for (int g = 0; g < gap; g++) begin
        tvalid = 1'b0;
        @(negedge clk);
        check_eq("gap_no_write", cfg_en, 0);
        tick();
      end
      tvalid = 1'b1;
      tdata  = 8'(base + b);
`ifdef THRESH_LOADER_TLAST_CHECK_EN
      tlast  = (b == last_beat);
`else
      if (b == last_beat) tdata = 8'(base + b);
`endif
      if (b == host_beat) begin
        h_en = 1'b1; h_we = 1'b1; h_a = 4'd5; h_d = 8'h77;
        @(negedge clk);
        check_eq("host_stall_tready", tready, 0);
        check_eq("host_wr_addr", cfg_a, 5);
        check_eq("host_wr_data", cfg_d, 8'h77);
        check_eq("host_wr_we", cfg_we, 1);
        tick();
        h_en = 1'b0; h_we = 1'b0;
        check_eq("host_wr_mem", mem[5], 8'h77);
      end
      @(negedge clk);
      check_eq("beat_tready", tready, 1);
      check_eq("beat_en", {cfg_en, cfg_we}, 2'b11);
      check_eq("beat_addr", cfg_a, exp_addr[b]);
      check_eq("beat_data", cfg_d, 32'(8'(base + b)));
      check_eq("no_early_done", ap_done, 0);
      tick();
      if (b == stop_after && stop_after < 11) return;
    end
    tvalid = 1'b0;
`ifdef THRESH_LOADER_TLAST_CHECK_EN
    tlast = 1'b0;
`endif
    @(negedge clk);
    check_eq("done_pulse", ap_done, 1);
    check_eq("done_ken", kernel_en, 1);
    check_eq("done_idle", ap_idle, 1);
    tick();
    @(negedge clk);
    check_eq("done_single", ap_done, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ap_start = 1'b0; tvalid = 1'b1; tdata = 8'h00;
    h_en = 1'b0; h_we = 1'b0; h_a = '0; h_d = '0; cfg_rack = 1'b0; cfg_q = '0;
`ifdef THRESH_LOADER_TLAST_CHECK_EN
    tlast = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_idle", ap_idle, 1);
    check_eq("rst_ken", kernel_en, 0);
    check_eq("rst_done", ap_done, 0);
    check_eq("rst_tready", tready, 0);
    check_eq("rst_cfg_en", cfg_en, 0);
`ifdef THRESH_LOADER_TLAST_CHECK_EN
    check_eq("rst_load_err", load_err, 0);
`endif
    rst_n = 1'b1; tvalid = 1'b0;
    tick();

    // back-to-back full load
    start_load();
    stream(8'h10, 0, -1, 11, 11);
    check_mem(8'h10);
    check_eq("done_cnt_1", done_cnt, 1);

    // reload from DONE with host write colliding with beat 4
    start_load();
    stream(8'h40, 0, 4, 11, 11);
    check_mem(8'h40);
    check_eq("done_cnt_2", done_cnt, 2);

    // host read passthrough in DONE
    h_en = 1'b1; h_we = 1'b0; h_a = 4'hE; cfg_rack = 1'b1; cfg_q = 8'hA5;
    @(negedge clk);
    check_eq("rd_rack", h_rack, 1);
    check_eq("rd_q", h_q, 8'hA5);
    check_eq("rd_cfg", {cfg_en, cfg_we, cfg_a}, {2'b10, 4'hE});
    check_eq("rd_ken", kernel_en, 1);
    tick();
    h_en = 1'b0; cfg_rack = 1'b0; cfg_q = 8'h00;
    @(negedge clk);
    check_eq("rd_rack_off", h_rack, 0);
    tick();

    // reset after beat 6 aborts the load
    start_load();
    stream(8'h60, 0, -1, 11, 6);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_idle", ap_idle, 1);
    check_eq("abort_ken", kernel_en, 0);
    check_eq("abort_done", ap_done, 0);
    check_eq("abort_tready", tready, 0);
    check_eq("abort_cfg_en", cfg_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; tvalid = 1'b0;
    tick();
    check_eq("abort_no_done", done_cnt, 2);
    start_load();
    stream(8'h80, 0, -1, 11, 11);
    check_mem(8'h80);
    check_eq("done_cnt_3", done_cnt, 3);

    // sparse TVALID, one beat every third cycle
    start_load();
    stream(8'hC0, 2, -1, 11, 11);
    check_mem(8'hC0);
    check_eq("done_cnt_4", done_cnt, 4);

`ifdef THRESH_LOADER_TLAST_CHECK_EN
    start_load();
    stream(8'h20, 0, -1, 7, 11);
    check_eq("tlast_early_err", load_err, 1);
    check_eq("done_cnt_5", done_cnt, 5);
    start_load();
    check_eq("tlast_err_cleared", load_err, 0);
    stream(8'h30, 0, -1, 11, 11);
    check_eq("tlast_ok_err", load_err, 0);
    check_eq("done_cnt_6", done_cnt, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
